// File: rtl/z80fi_pkg.sv
// z80fi shared definitions: default widths, register slot
// offsets inside the REGW snapshot, collector state enum.
package z80fi_pkg;

  localparam int MAXLEN_DEF = 4;
  localparam int REGW_DEF   = 208;
  localparam int RW         = 16;

  // Bit offsets of each 16-bit register in the snapshot.
  localparam int OFF_AF  = 0 * RW;
  localparam int OFF_BC  = 1 * RW;
  localparam int OFF_DE  = 2 * RW;
  localparam int OFF_HL  = 3 * RW;
  localparam int OFF_AF2 = 4 * RW;
  localparam int OFF_BC2 = 5 * RW;
  localparam int OFF_DE2 = 6 * RW;
  localparam int OFF_HL2 = 7 * RW;
  localparam int OFF_IX  = 8 * RW;
  localparam int OFF_IY  = 9 * RW;
  localparam int OFF_SP  = 10 * RW;
  localparam int OFF_IR  = 11 * RW;
  localparam int OFF_IP  = 12 * RW;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } col_state_e;

  function automatic logic [RW-1:0] reg_at(
    input logic [REGW_DEF-1:0] regs,
    input int                  off
  );
    return regs[off +: RW];
  endfunction

endpackage

// File: rtl/z80fi_byte_buffer.sv
// Instruction byte buffer: clear-and-load slot 0, write at count,
// saturate at MAXLEN with sticky overflow.
// Ports: i_clear opens, i_wr appends i_data; o_app_* expose the
// contents with this cycle's append applied (used for retire).
module z80fi_byte_buffer
  import z80fi_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEF
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_wr,
  input  logic [7:0]          i_data,
  output logic [8*MAXLEN-1:0] o_app_buf,
  output logic [2:0]          o_app_cnt,
  output logic                o_app_ovf
);

  logic [8*MAXLEN-1:0] r_buf;
  logic [2:0]          r_cnt;
  logic                r_ovf;

  always_comb begin
    o_app_buf = r_buf;
    o_app_cnt = r_cnt;
    o_app_ovf = r_ovf;
    if (i_wr) begin
      if (r_cnt == 3'(MAXLEN)) begin
        o_app_ovf = 1'b1;
      end else begin
        for (int k = 0; k < MAXLEN; k++) begin
          if (r_cnt == 3'(k))
            o_app_buf[8*k +: 8] = i_data;
        end
        o_app_cnt = r_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_buf <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_buf <= {{(8*(MAXLEN-1)){1'b0}}, i_data};
      r_cnt <= 3'd1;
      r_ovf <= 1'b0;
    end else begin
      r_buf <= o_app_buf;
      r_cnt <= o_app_cnt;
      r_ovf <= o_app_ovf;
    end
  end

endmodule

// File: rtl/z80fi_insn_collector.sv
// z80fi producer: assembles one retirement packet per instruction
// from fetch-byte and retire strobes. Outputs registered, 1-cycle.
module z80fi_insn_collector
  import z80fi_pkg::*;
#(
  parameter int REGW   = REGW_DEF,
  parameter int MAXLEN = MAXLEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                byte_valid,
  input  logic                byte_first,
  input  logic [7:0]          byte_data,
  input  logic                insn_done,
  input  logic [REGW-1:0]     regs_now,
  output logic                z80fi_valid,
  output logic [8*MAXLEN-1:0] z80fi_insn,
  output logic [2:0]          z80fi_insn_len,
  output logic [REGW-1:0]     z80fi_regs_in,
  output logic [REGW-1:0]     z80fi_regs_out,
  output logic                z80fi_error
);

  col_state_e r_state;
  col_state_e w_state_nxt;

  logic                r_valid;
  logic                r_error;
  logic [8*MAXLEN-1:0] r_insn;
  logic [2:0]          r_len;
  logic [REGW-1:0]     r_shadow;
  logic [REGW-1:0]     r_regs_in;
  logic [REGW-1:0]     r_regs_out;

  logic                w_open;
  logic                w_cont;
  logic                w_wr;
  logic                w_retire;
  logic                w_vld_nxt;
  logic                w_err_nxt;
  logic [8*MAXLEN-1:0] w_app_buf;
  logic [2:0]          w_app_cnt;
  logic                w_app_ovf;

  assign w_open = byte_valid & byte_first;
  assign w_cont = byte_valid & ~byte_first;
  // Continuation bytes only land while an instruction is open.
  assign w_wr   = w_cont & (r_state == COLLECT);

  z80fi_byte_buffer #(
    .MAXLEN (MAXLEN)
  ) u_buf (
    .clk       (clk),
    .i_reset   (reset),
    .i_clear   (w_open),
    .i_wr      (w_wr),
    .i_data    (byte_data),
    .o_app_buf (w_app_buf),
    .o_app_cnt (w_app_cnt),
    .o_app_ovf (w_app_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    w_vld_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (insn_done || w_cont)
          w_err_nxt = 1'b1;
        if (w_open)
          w_state_nxt = COLLECT;
      end
      COLLECT: begin
        if (insn_done) begin
          // A same-cycle first byte opens the next one.
          w_retire    = 1'b1;
          w_vld_nxt   = 1'b1;
          w_err_nxt   = w_app_ovf;
          w_state_nxt = w_open ? COLLECT : IDLE;
        end else if (w_open) begin
          w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_insn     <= '0;
      r_len      <= '0;
      r_shadow   <= '0;
      r_regs_in  <= '0;
      r_regs_out <= '0;
    end else begin
      r_valid <= w_vld_nxt;
      r_error <= w_err_nxt;
      if (w_open)
        r_shadow <= regs_now;
      if (w_retire) begin
        r_insn     <= w_app_buf;
        r_len      <= w_app_cnt;
        r_regs_in  <= r_shadow;
        r_regs_out <= regs_now;
      end
    end
  end

  assign z80fi_valid    = r_valid;
  assign z80fi_error    = r_error;
  assign z80fi_insn     = r_insn;
  assign z80fi_insn_len = r_len;
  assign z80fi_regs_in  = r_regs_in;
  assign z80fi_regs_out = r_regs_out;

endmodule

// File: tb/tb_z80fi_insn_collector.sv
// Bench for z80fi_insn_collector: directed packets then random
// strobes against a queue-based reference of the packet rules.
module tb_z80fi_insn_collector;
  import z80fi_pkg::*;

  localparam int REGW   = REGW_DEF;
  localparam int MAXLEN = MAXLEN_DEF;

  logic                clk = 1'b0;
  logic                reset;
  logic                byte_valid;
  logic                byte_first;
  logic [7:0]          byte_data;
  logic                insn_done;
  logic [REGW-1:0]     regs_now;
  logic                z80fi_valid;
  logic [8*MAXLEN-1:0] z80fi_insn;
  logic [2:0]          z80fi_insn_len;
  logic [REGW-1:0]     z80fi_regs_in;
  logic [REGW-1:0]     z80fi_regs_out;
  logic                z80fi_error;

  z80fi_insn_collector #(.REGW(REGW), .MAXLEN(MAXLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .byte_valid     (byte_valid),
    .byte_first     (byte_first),
    .byte_data      (byte_data),
    .insn_done      (insn_done),
    .regs_now       (regs_now),
    .z80fi_valid    (z80fi_valid),
    .z80fi_insn     (z80fi_insn),
    .z80fi_insn_len (z80fi_insn_len),
    .z80fi_regs_in  (z80fi_regs_in),
    .z80fi_regs_out (z80fi_regs_out),
    .z80fi_error    (z80fi_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]          m_q[$];
  bit                  m_open;
  bit                  m_ovf;
  logic [REGW-1:0]     m_rin;
  logic                e_valid;
  logic                e_error;
  logic [8*MAXLEN-1:0] e_insn;
  logic [2:0]          e_len;
  logic [REGW-1:0]     e_rin;
  logic [REGW-1:0]     e_rout;
  logic [REGW-1:0]     saved_regs;

  task automatic chk(input string tag, input logic [REGW-1:0] got,
                     input logic [REGW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all();
    chk("valid", REGW'(z80fi_valid), REGW'(e_valid));
    chk("error", REGW'(z80fi_error), REGW'(e_error));
    chk("insn", REGW'(z80fi_insn), REGW'(e_insn));
    chk("len", REGW'(z80fi_insn_len), REGW'(e_len));
    chk("regs_in", z80fi_regs_in, e_rin);
    chk("regs_out", z80fi_regs_out, e_rout);
  endtask

  function automatic logic [REGW-1:0] rand_regs();
    logic [REGW-1:0] r;
    for (int i = 0; i < REGW / 16; i++)
      r[16*i +: 16] = 16'($urandom);
    return r;
  endfunction

  // One clock of stimulus; model predicts the next-cycle outputs.
  task automatic step(input bit bv, input bit bf, input logic [7:0] bd,
                      input bit done);
    logic [REGW-1:0] rg;
    bit opn, cont;
    rg = rand_regs();
    reset = 1'b0;
    byte_valid = bv; byte_first = bf; byte_data = bd;
    insn_done = done; regs_now = rg;
    opn  = bv && bf;
    cont = bv && !bf;
    e_valid = 1'b0;
    e_error = 1'b0;
    if (m_open) begin
      if (cont) begin
        if (m_q.size() < MAXLEN) m_q.push_back(bd);
        else m_ovf = 1'b1;
      end
      if (done) begin
        e_valid = 1'b1;
        e_insn  = '0;
        foreach (m_q[i]) e_insn[8*i +: 8] = m_q[i];
        e_len   = 3'(m_q.size());
        e_rin   = m_rin;
        e_rout  = rg;
        e_error = m_ovf;
        m_open  = 1'b0;
      end else if (opn) begin
        e_error = 1'b1;
      end
    end else if (done || cont) begin
      e_error = 1'b1;
    end
    if (opn) begin
      m_q = {bd};
      m_ovf = 1'b0;
      m_open = 1'b1;
      m_rin = rg;
    end
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    byte_valid = 1'($urandom); byte_first = 1'($urandom);
    byte_data = 8'($urandom); insn_done = 1'($urandom);
    regs_now = rand_regs();
    m_q = {}; m_open = 1'b0; m_ovf = 1'b0; m_rin = '0;
    e_valid = 1'b0; e_error = 1'b0; e_insn = '0; e_len = '0;
    e_rin = '0; e_rout = '0;
    @(posedge clk);
    #1;
    chk_all();
  endtask

  initial begin
    do_reset();
    do_reset();

    // LD IX,nn
    step(1, 1, 8'hDD, 0);
    step(1, 0, 8'h21, 0);
    step(1, 0, 8'h34, 0);
    step(1, 0, 8'h12, 1);
    chk("ldix_insn", REGW'(z80fi_insn), REGW'(32'h123421DD));
    chk("ldix_len", REGW'(z80fi_insn_len), REGW'(3'd4));
    chk("ldix_valid", REGW'(z80fi_valid), REGW'(1'b1));
    chk("ldix_error", REGW'(z80fi_error), REGW'(1'b0));

    // Back-to-back NOP then INC A
    step(1, 1, 8'h00, 0);
    step(1, 1, 8'h3C, 1);
    saved_regs = regs_now;
    chk("b2b_insn0", REGW'(z80fi_insn), REGW'(32'h0));
    chk("b2b_len0", REGW'(z80fi_insn_len), REGW'(3'd1));
    chk("b2b_rout0", z80fi_regs_out, saved_regs);
    step(0, 0, 8'h00, 1);
    chk("b2b_insn1", REGW'(z80fi_insn), REGW'(32'h3C));
    chk("b2b_valid1", REGW'(z80fi_valid), REGW'(1'b1));

    // Overflow
    step(1, 1, 8'hFD, 0);
    step(1, 0, 8'h21, 0);
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h10, 0);
    step(1, 0, 8'hAA, 0);
    step(0, 0, 8'h00, 1);
    chk("ovf_insn", REGW'(z80fi_insn), REGW'(32'h100021FD));
    chk("ovf_err", REGW'(z80fi_error), REGW'(1'b1));
    chk("ovf_valid", REGW'(z80fi_valid), REGW'(1'b1));

    // Abandon
    step(1, 1, 8'hDD, 0);
    step(1, 0, 8'h21, 0);
    step(1, 1, 8'h76, 0);
    chk("abn_err", REGW'(z80fi_error), REGW'(1'b1));
    chk("abn_valid", REGW'(z80fi_valid), REGW'(1'b0));
    step(0, 0, 8'h00, 1);
    chk("abn_insn", REGW'(z80fi_insn), REGW'(32'h76));

    // Stray done / stray byte in IDLE
    step(0, 0, 8'h00, 1);
    chk("stray_done", REGW'(z80fi_error), REGW'(1'b1));
    step(1, 0, 8'h55, 0);
    chk("stray_byte", REGW'(z80fi_error), REGW'(1'b1));
    step(0, 0, 8'h00, 0);

    // Reset mid-collection, then done in IDLE
    step(1, 1, 8'hDD, 0);
    step(1, 0, 8'h21, 0);
    do_reset();
    chk("rst_insn", REGW'(z80fi_insn), REGW'(0));
    step(0, 0, 8'h00, 1);
    chk("rst_err", REGW'(z80fi_error), REGW'(1'b1));
    chk("rst_valid", REGW'(z80fi_valid), REGW'(1'b0));

    // Random strobes
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
             8'($urandom), $urandom_range(0, 3) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
